// File: rtl/sd_loader_pkg.sv
// Shared types and constants for the SD block loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4,
    FIN  = 3'd5
  } LoaderState;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [3:0] WSTRB_FULL      = 4'hF;

endpackage

// File: rtl/sd_block_loader.sv
// AXI-lite master copying a block of 32-bit words from a source window to a destination window.
// Latency: 4 cycles per word with a zero-wait slave (AR, R, AW/W, B); done one cycle after last B.
// Backpressure: every channel waits indefinitely on its ready/valid; one transaction outstanding.
module sd_block_loader
  import sd_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_left,
  output logic [31:0]      m_axil_awaddr,
  output logic [2:0]       m_axil_awprot,
  output logic             m_axil_awvalid,
  input  logic             m_axil_awready,
  output logic [31:0]      m_axil_wdata,
  output logic [3:0]       m_axil_wstrb,
  output logic             m_axil_wvalid,
  input  logic             m_axil_wready,
  input  logic [1:0]       m_axil_bresp,
  input  logic             m_axil_bvalid,
  output logic             m_axil_bready,
  output logic [31:0]      m_axil_araddr,
  output logic [2:0]       m_axil_arprot,
  output logic             m_axil_arvalid,
  input  logic             m_axil_arready,
  input  logic [31:0]      m_axil_rdata,
  input  logic [1:0]       m_axil_rresp,
  input  logic             m_axil_rvalid,
  output logic             m_axil_rready
);

  LoaderState state_q, state_d;

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] left_q;
  logic             aw_done_q;
  logic             w_done_q;
  logic             err_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic bad_r, bad_b, aw_all, w_all, accept;

  // All AXI outputs decode from registered state/flags only, so no ready->valid path exists.
  assign m_axil_arvalid = (state_q == AR);
  assign m_axil_araddr  = src_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_rready  = (state_q == R);
  assign m_axil_awvalid = (state_q == AW_W) && !aw_done_q;
  assign m_axil_awaddr  = dst_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_wvalid  = (state_q == AW_W) && !w_done_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = WSTRB_FULL;
  assign m_axil_bready  = (state_q == B);

  assign busy       = (state_q == AR) || (state_q == R) || (state_q == AW_W) || (state_q == B);
  assign done       = (state_q == FIN);
  assign error      = err_q;
  assign words_left = left_q;

  assign ar_hs  = m_axil_arvalid && m_axil_arready;
  assign r_hs   = m_axil_rready && m_axil_rvalid;
  assign aw_hs  = m_axil_awvalid && m_axil_awready;
  assign w_hs   = m_axil_wvalid && m_axil_wready;
  assign b_hs   = m_axil_bready && m_axil_bvalid;
  assign bad_r  = r_hs && (m_axil_rresp != AXI_RESP_OKAY);
  assign bad_b  = b_hs && (m_axil_bresp != AXI_RESP_OKAY);
  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign aw_all = aw_done_q || aw_hs;
  assign w_all  = w_done_q || w_hs;
  assign accept = (state_q == IDLE) && start && (word_count != '0);

  // State register; async reset drops every valid immediately.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; a zero-length start goes straight to FIN so done pulses without busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (word_count == '0) ? FIN : AR;
      AR:   if (ar_hs) state_d = R;
      R:    if (r_hs)  state_d = bad_r ? IDLE : AW_W;
      AW_W: if (aw_all && w_all) state_d = B;
      B: begin
        if (b_hs) begin
          if (bad_b)                    state_d = IDLE;
          else if (left_q == CNT_W'(1)) state_d = FIN;
          else                          state_d = AR;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the command, capture read data, track AW/W completion, advance per word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      left_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= bad_r || bad_b;
      if (accept) begin
        src_q  <= {src_addr[31:2], 2'b00};
        dst_q  <= {dst_addr[31:2], 2'b00};
        left_q <= word_count;
      end
      if (r_hs) data_q <= m_axil_rdata;
      if (state_q == AW_W) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (b_hs && !bad_b) begin
        src_q  <= src_q + 32'd4;
        dst_q  <= dst_q + 32'd4;
        left_q <= left_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sd_block_loader.sv
// Self-checking bench for sd_block_loader: randomized AXI-lite slave plus a block-copy model.
// Latency: checks per-word timing for a zero-wait slave and completion for stalled slaves.
// Backpressure: slave readies and response valids are randomly delayed when bp is set.
module tb_sd_block_loader;
  import sd_loader_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, error;
  logic [15:0] words_left;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  sd_block_loader #(.CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error), .words_left(words_left),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // Model of the current transfer: expected addresses/data and how many of each must occur.
  logic [31:0] exp_ar[64];
  logic [31:0] exp_aw[64];
  logic [31:0] obs_ar[64];
  logic [31:0] obs_aw[64];
  int exp_nrd, exp_nwr;
  int err_word = -1;
  bit bp = 0;

  // Slave/monitor state.
  bit p_ar, p_r, p_aw, p_w, p_b;
  bit pv_ar, pv_aw, pv_w;
  logic [31:0] pv_araddr, pv_awaddr, pv_wdata;
  bit r_pend, b_pend, aw_got, w_got;
  logic [31:0] r_addr;
  int rd_n, ar_i, aw_i, w_i, b_i;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock cycle: acts as the AXI-lite slave and checks every handshake against the model.
  task automatic tick();
    @(negedge aclk);
    if (!aresetn) begin
      {p_ar, p_r, p_aw, p_w, p_b, pv_ar, pv_aw, pv_w} = '0;
      {r_pend, b_pend, aw_got, w_got} = '0;
      rvalid = 1'b0; bvalid = 1'b0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      return;
    end
    // Consequences of handshakes that happened on the previous rising edge.
    if (p_r) rvalid = 1'b0;
    if (p_b) bvalid = 1'b0;
    if (p_ar) begin r_pend = 1; r_addr = pv_araddr; end
    if (p_aw) aw_got = 1;
    if (p_w)  w_got = 1;
    if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
    if (r_pend && !rvalid && (!bp || $urandom_range(0, 1) == 1)) begin
      rvalid = 1'b1;
      rdata  = mem(r_addr);
      rresp  = (rd_n == err_word) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      rd_n++;
      r_pend = 0;
    end
    if (b_pend && !bvalid && (!bp || $urandom_range(0, 1) == 1)) begin
      bvalid = 1'b1; bresp = AXI_RESP_OKAY; b_pend = 0;
    end
    arready = !bp || ($urandom_range(0, 2) == 0);
    awready = !bp || ($urandom_range(0, 2) == 0);
    wready  = !bp || ($urandom_range(0, 2) == 0);
    // A valid that was not accepted must still be asserted with identical payload.
    if (pv_ar && !p_ar) begin
      chk("arvalid_held", 32'(arvalid), 32'd1);
      chk("araddr_stable", araddr, pv_araddr);
    end
    if (pv_aw && !p_aw) begin
      chk("awvalid_held", 32'(awvalid), 32'd1);
      chk("awaddr_stable", awaddr, pv_awaddr);
    end
    if (pv_w && !p_w) begin
      chk("wvalid_held", 32'(wvalid), 32'd1);
      chk("wdata_stable", wdata, pv_wdata);
    end
    // Handshakes that will occur on the next rising edge.
    p_ar = arvalid && arready;
    p_r  = rvalid && rready;
    p_aw = awvalid && awready;
    p_w  = wvalid && wready;
    p_b  = bvalid && bready;
    if (p_ar) begin
      chk("ar_after_prev_b", 32'(b_i), 32'(ar_i));
      chk("arprot", 32'(arprot), 32'd0);
      if (ar_i < exp_nrd) chk("araddr", araddr, exp_ar[ar_i]);
      else chk("ar_extra", 32'(ar_i), 32'(exp_nrd));
      if (ar_i < 64) obs_ar[ar_i] = araddr;
      ar_i++;
    end
    if (p_aw) begin
      chk("awprot", 32'(awprot), 32'd0);
      if (aw_i < exp_nwr) chk("awaddr", awaddr, exp_aw[aw_i]);
      else chk("aw_extra", 32'(aw_i), 32'(exp_nwr));
      if (aw_i < 64) obs_aw[aw_i] = awaddr;
      aw_i++;
    end
    if (p_w) begin
      chk("wstrb", 32'(wstrb), 32'hF);
      if (w_i < exp_nwr) chk("wdata", wdata, mem(exp_ar[w_i]));
      else chk("w_extra", 32'(w_i), 32'(exp_nwr));
      w_i++;
    end
    if (p_b) b_i++;
    pv_ar = arvalid; pv_araddr = araddr;
    pv_aw = awvalid; pv_awaddr = awaddr;
    pv_w  = wvalid;  pv_wdata  = wdata;
  endtask

  task automatic set_model(input logic [31:0] s, input logic [31:0] d, input int n, input int ew);
    for (int i = 0; i < n; i++) begin
      exp_ar[i] = {s[31:2], 2'b00} + 32'(4 * i);
      exp_aw[i] = {d[31:2], 2'b00} + 32'(4 * i);
    end
    err_word = ew;
    exp_nrd = (ew >= 0) ? ew + 1 : n;
    exp_nwr = (ew >= 0) ? ew : n;
    rd_n = 0; ar_i = 0; aw_i = 0; w_i = 0; b_i = 0;
  endtask

  // Full transfer: pulse start, wait (bounded) for done/error, then check the final status.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input int ew,
                     input bit use_bp, input bit poke, output int lat);
    int t;
    bit fin, busy_ok;
    bp = use_bp;
    set_model(s, d, n, ew);
    src_addr = s; dst_addr = d; word_count = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0; fin = 0; busy_ok = 1;
    while (!fin && t < 3000) begin
      if (done || error) fin = 1;
      else begin
        if (!busy) busy_ok = 0;
        tick();
        t++;
        if (poke) begin
          start = (t == 3);
          src_addr = 32'hDEAD_0000; word_count = 16'd7;
        end
      end
    end
    start = 1'b0;
    lat = t;
    chk("completes", 32'(fin), 32'd1);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("done_pulse", 32'(done), 32'(ew < 0));
    chk("error_pulse", 32'(error), 32'(ew >= 0));
    chk("busy_at_end", 32'(busy), 32'd0);
    chk("words_left", 32'(words_left), (ew >= 0) ? 32'(n - ew) : 32'd0);
    chk("n_reads", 32'(ar_i), 32'(exp_nrd));
    chk("n_aw", 32'(aw_i), 32'(exp_nwr));
    chk("n_w", 32'(w_i), 32'(exp_nwr));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("error_one_cycle", 32'(error), 32'd0);
    tick();
  endtask

  initial begin
    int lat, t;
    bit seen;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
    chk("rst_readies", 32'({bready, rready}), 32'd0);
    chk("rst_words_left", 32'(words_left), 32'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // Zero-wait copy of 4 words; 4 cycles per word.
    run(32'h0000_0000, 32'h0010_0000, 4, -1, 0, 0, lat);
    chk("lat_16", 32'(lat), 32'd16);
    chk("t1_ar3", obs_ar[3], 32'h0000_000C);
    chk("t1_aw0", obs_aw[0], 32'h0010_0000);
    chk("t1_aw3", obs_aw[3], 32'h0010_000C);

    // Same copy with backpressure on every channel.
    run(32'h0000_0000, 32'h0010_0000, 4, -1, 1, 0, lat);

    // SLVERR on the second of three reads.
    run(32'h0000_0200, 32'h0000_8000, 3, 1, 0, 0, lat);
    chk("t3_one_write", 32'(aw_i), 32'd1);

    // Zero-length start: done next cycle, no AXI activity, busy never set.
    set_model(32'h0, 32'h0, 0, -1);
    word_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_arvalid", 32'(arvalid), 32'd0);
    tick();
    chk("zero_done_off", 32'(done), 32'd0);

    // Start while busy is ignored.
    run(32'h0000_4000, 32'h0000_5003, 3, -1, 0, 1, lat);

    // Source wraps past the top of the address space; unaligned low bits dropped.
    run(32'hFFFF_FFFB, 32'h0020_0000, 3, -1, 1, 0, lat);
    chk("wrap_ar0", obs_ar[0], 32'hFFFF_FFF8);
    chk("wrap_ar1", obs_ar[1], 32'hFFFF_FFFC);
    chk("wrap_ar2", obs_ar[2], 32'h0000_0000);

    // Randomized transfers, some with a read error.
    for (int k = 0; k < 6; k++) begin
      int n, ew;
      n = int'($urandom_range(1, 10));
      ew = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run($urandom, $urandom, n, ew, 1'($urandom_range(0, 1)), 0, lat);
    end

    // Reset asserted while the write channels are active.
    bp = 0;
    set_model(32'h0000_1000, 32'h0000_9000, 2, -1);
    src_addr = 32'h0000_1000; dst_addr = 32'h0000_9000; word_count = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0; t = 0;
    while (!seen && t < 100) begin
      if (awvalid && wvalid) seen = 1;
      else begin tick(); t++; end
    end
    chk("reach_aw_w", 32'(seen), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_awvalid", 32'(awvalid), 32'd0);
    chk("mid_rst_wvalid", 32'(wvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words_left", 32'(words_left), 32'd0);
    tick(); tick();
    chk("mid_rst_no_done", 32'(done), 32'd0);
    aresetn = 1'b1;
    tick();
    run(32'h0000_2000, 32'h0000_3000, 1, -1, 0, 0, lat);
    chk("lat_1word", 32'(lat), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
